// File: rtl/caravel_efuse_pkg.sv
// Shared types and sizes for the Caravel Wishbone eFuse block.
// Controller state encoding plus fuse array geometry.
package caravel_efuse_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_READ = 2'd1,
      ST_PROG = 2'd2,
      ST_ACK  = 2'd3
   } efuse_state_e;

   localparam int unsigned FUSE_WORDS = 64;
   localparam int unsigned FUSE_BITS  = 8;
   localparam int unsigned IDX_W      = 6;

endpackage

// File: rtl/caravel_efuse_array.sv
// Behavioural 64x8 one-time-programmable fuse storage.
// Bits can only be set (OR-program); there is deliberately no reset.
module caravel_efuse_array
   import caravel_efuse_pkg::*;
(
   input  logic                 clk,
   input  logic [IDX_W-1:0]     rd_idx,
   output logic [FUSE_BITS-1:0] rd_data,
   input  logic                 prog_en,
   input  logic [IDX_W-1:0]     prog_idx,
   input  logic [FUSE_BITS-1:0] prog_mask
);

   // Unprogrammed fuses read as zero from power-up; reset never touches them.
   logic [FUSE_BITS-1:0] fuse_q [FUSE_WORDS] = '{default: '0};

   always_ff @(posedge clk) begin
      if (prog_en) begin
         fuse_q[prog_idx] <= fuse_q[prog_idx] | prog_mask;
      end
   end

   assign rd_data = fuse_q[rd_idx];

endmodule

// File: rtl/caravel_efuse_wb.sv
// Wishbone slave front-end for the eFuse array: address decode and a
// controller FSM that models sense time and program-pulse time.
//
// state | meaning
// IDLE  | waiting for a decoded request; inputs sampled only here
// READ  | sensing the addressed fuse byte for READ_CYCLES cycles
// PROG  | program pulse for PROG_CYCLES cycles, OR-write on the last one
// ACK   | one-cycle acknowledge
module caravel_efuse_wb
   import caravel_efuse_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR   = 32'h3000_0000,
   parameter int unsigned READ_CYCLES = 2,
   parameter int unsigned PROG_CYCLES = 16
) (
   input  logic        wb_clk_i,
   input  logic        wb_rst_i,
   input  logic        wbs_cyc_i,
   input  logic        wbs_stb_i,
   input  logic        wbs_we_i,
   input  logic [3:0]  wbs_sel_i,
   input  logic [31:0] wbs_adr_i,
   input  logic [31:0] wbs_dat_i,
   output logic        wbs_ack_o,
   output logic [31:0] wbs_dat_o,
   output logic        busy_o
);

   localparam int unsigned MAX_CYCLES = (PROG_CYCLES > READ_CYCLES) ? PROG_CYCLES : READ_CYCLES;
   localparam int unsigned CNT_W      = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;

   efuse_state_e         state_q, state_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic [IDX_W-1:0]     idx_q, idx_d;
   logic [FUSE_BITS-1:0] mask_q, mask_d;
   logic                 sel0_q, sel0_d;
   logic [31:0]          dat_q, dat_d;
   logic                 prog_en;
   logic                 req;
   logic [FUSE_BITS-1:0] rd_data;
   logic                 unused_bits;

   assign unused_bits = ^{wbs_sel_i[3:1], wbs_adr_i[1:0], wbs_dat_i[31:8]};

   assign req = wbs_cyc_i & wbs_stb_i & (wbs_adr_i[31:8] == BASE_ADDR[31:8]) & ~wbs_ack_o;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      idx_d   = idx_q;
      mask_d  = mask_q;
      sel0_d  = sel0_q;
      dat_d   = dat_q;
      prog_en = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (req) begin
               idx_d = wbs_adr_i[7:2];
               if (wbs_we_i) begin
                  mask_d  = wbs_dat_i[7:0];
                  sel0_d  = wbs_sel_i[0];
                  cnt_d   = CNT_W'(PROG_CYCLES - 1);
                  state_d = ST_PROG;
               end else begin
                  cnt_d   = CNT_W'(READ_CYCLES - 1);
                  state_d = ST_READ;
               end
            end
         end
         ST_READ: begin
            if (cnt_q == '0) begin
               dat_d   = {24'b0, rd_data};
               state_d = ST_ACK;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         ST_PROG: begin
            // Fuse update is atomic at terminal count so an aborted pulse leaves no trace.
            if (cnt_q == '0) begin
               prog_en = sel0_q;
               state_d = ST_ACK;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         ST_ACK:  state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         idx_q   <= '0;
         mask_q  <= '0;
         sel0_q  <= 1'b0;
         dat_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         mask_q  <= mask_d;
         sel0_q  <= sel0_d;
         dat_q   <= dat_d;
      end
   end

   caravel_efuse_array u_array (
      .clk       (wb_clk_i),
      .rd_idx    (idx_q),
      .rd_data   (rd_data),
      .prog_en   (prog_en),
      .prog_idx  (idx_q),
      .prog_mask (mask_q)
   );

   assign wbs_ack_o = (state_q == ST_ACK);
   assign wbs_dat_o = dat_q;
   assign busy_o    = (state_q == ST_READ) || (state_q == ST_PROG);

endmodule

// File: tb/tb_caravel_efuse_wb.sv
// Self-checking bench for caravel_efuse_wb: directed scenarios then random
// traffic against a fuse-byte model with OR-only programming.
module tb_caravel_efuse_wb;

   localparam logic [31:0] BASE = 32'h3000_0000;
   localparam int RD_LAT = 3;
   localparam int WR_LAT = 17;

   logic        wb_clk_i = 1'b0;
   logic        wb_rst_i;
   logic        wbs_cyc_i, wbs_stb_i, wbs_we_i;
   logic [3:0]  wbs_sel_i;
   logic [31:0] wbs_adr_i, wbs_dat_i;
   logic        wbs_ack_o;
   logic [31:0] wbs_dat_o;
   logic        busy_o;

   int n_chk  = 0;
   int n_fail = 0;

   logic [7:0]  model_fuse [64];
   logic [31:0] model_dat;

   always #5 wb_clk_i = ~wb_clk_i;

   caravel_efuse_wb dut (
      .wb_clk_i  (wb_clk_i),
      .wb_rst_i  (wb_rst_i),
      .wbs_cyc_i (wbs_cyc_i),
      .wbs_stb_i (wbs_stb_i),
      .wbs_we_i  (wbs_we_i),
      .wbs_sel_i (wbs_sel_i),
      .wbs_adr_i (wbs_adr_i),
      .wbs_dat_i (wbs_dat_i),
      .wbs_ack_o (wbs_ack_o),
      .wbs_dat_o (wbs_dat_o),
      .busy_o    (busy_o)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   // Caller is always positioned 1 time unit after a rising edge.
   task automatic xfer(input logic [31:0] adr, input logic we, input logic [3:0] sel,
                       input logic [31:0] dat, input bit drop, input int budget,
                       output bit acked, output int lat, output int busy_n, output logic [31:0] rdat);
      acked = 0; lat = 0; busy_n = 0; rdat = '0;
      wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = we;
      wbs_sel_i = sel;  wbs_adr_i = adr;  wbs_dat_i = dat;
      for (int i = 0; i < budget; i++) begin
         @(posedge wb_clk_i); #1;
         lat++;
         if (drop) begin
            wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0;
            wbs_adr_i = $urandom; wbs_dat_i = $urandom; wbs_we_i = 1'($urandom);
         end
         if (busy_o) busy_n++;
         if (wbs_ack_o) begin
            acked = 1;
            rdat  = wbs_dat_o;
            break;
         end
      end
      wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; wbs_we_i = 1'b0;
   endtask

   task automatic ack_drop(input string tag);
      @(posedge wb_clk_i); #1;
      chk({tag, "_ack_one_cycle"}, 32'(wbs_ack_o), 32'd0);
   endtask

   task automatic do_read(input string tag, input int idx, input bit drop);
      bit ok; int lat, bn; logic [31:0] rd;
      xfer(BASE + 32'(idx * 4) + 32'($urandom_range(0, 3)), 1'b0, 4'($urandom), $urandom,
           drop, 40, ok, lat, bn, rd);
      model_dat = {24'b0, model_fuse[idx]};
      chk({tag, "_acked"}, 32'(ok), 32'd1);
      chk({tag, "_lat"}, 32'(lat), 32'(RD_LAT));
      chk({tag, "_busy"}, 32'(bn), 32'(RD_LAT - 1));
      chk({tag, "_data"}, rd, model_dat);
      ack_drop(tag);
   endtask

   task automatic do_write(input string tag, input int idx, input logic [7:0] mask,
                           input logic [3:0] sel, input bit drop);
      bit ok; int lat, bn; logic [31:0] rd;
      xfer(BASE + 32'(idx * 4), 1'b1, sel, {$urandom_range(0, 32'hFF_FFFF), mask},
           drop, 40, ok, lat, bn, rd);
      if (sel[0]) model_fuse[idx] = model_fuse[idx] | mask;
      chk({tag, "_acked"}, 32'(ok), 32'd1);
      chk({tag, "_lat"}, 32'(lat), 32'(WR_LAT));
      chk({tag, "_busy"}, 32'(bn), 32'(WR_LAT - 1));
      chk({tag, "_dat_hold"}, rd, model_dat);
      ack_drop(tag);
   endtask

   initial begin
      bit ok; int lat, bn; logic [31:0] rd;
      int idx;

      for (int i = 0; i < 64; i++) model_fuse[i] = 8'h00;
      model_dat = '0;
      wb_rst_i = 1'b1; wbs_cyc_i = 0; wbs_stb_i = 0; wbs_we_i = 0;
      wbs_sel_i = '0; wbs_adr_i = '0; wbs_dat_i = '0;
      repeat (3) @(posedge wb_clk_i);
      #1 wb_rst_i = 1'b0;
      chk("rst_ack", 32'(wbs_ack_o), 32'd0);
      chk("rst_dat", wbs_dat_o, 32'd0);
      chk("rst_busy", 32'(busy_o), 32'd0);

      do_read("rd0", 0, 0);
      do_write("wr_a5", 3, 8'hA5, 4'b0001, 0);
      do_read("rd3_a5", 3, 0);
      do_read("rd2", 2, 0);
      do_read("rd4", 4, 0);
      do_write("wr_5a", 3, 8'h5A, 4'b0001, 0);
      do_read("rd3_ff", 3, 0);
      do_write("wr_00", 3, 8'h00, 4'b0001, 0);
      do_read("rd3_ff2", 3, 0);
      do_write("wr_nosel", 63, 8'h3C, 4'b1110, 0);
      do_read("rd63", 63, 0);

      // Reset in the middle of a program pulse must abort it.
      wbs_cyc_i = 1; wbs_stb_i = 1; wbs_we_i = 1; wbs_sel_i = 4'b0001;
      wbs_adr_i = BASE + 32'h28; wbs_dat_i = 32'hFF;
      repeat (8) @(posedge wb_clk_i);
      #1;
      chk("prog_busy_mid", 32'(busy_o), 32'd1);
      wbs_cyc_i = 0; wbs_stb_i = 0; wbs_we_i = 0;
      wb_rst_i = 1'b1;
      @(posedge wb_clk_i); #1 wb_rst_i = 1'b0;
      chk("prog_rst_busy", 32'(busy_o), 32'd0);
      ok = 0;
      for (int i = 0; i < 20; i++) begin
         @(posedge wb_clk_i); #1;
         if (wbs_ack_o) ok = 1;
      end
      chk("prog_rst_noack", 32'(ok), 32'd0);
      model_dat = '0;
      do_read("rd10_abort", 10, 0);
      do_read("rd3_survive", 3, 0);

      // Reset in the middle of a sense clears read data and suppresses ack.
      wbs_cyc_i = 1; wbs_stb_i = 1; wbs_we_i = 0; wbs_adr_i = BASE + 32'h0C;
      @(posedge wb_clk_i); #1;
      wbs_cyc_i = 0; wbs_stb_i = 0;
      wb_rst_i = 1'b1;
      @(posedge wb_clk_i); #1 wb_rst_i = 1'b0;
      chk("rd_rst_dat", wbs_dat_o, 32'd0);
      chk("rd_rst_ack", 32'(wbs_ack_o), 32'd0);
      model_dat = '0;

      xfer(BASE + 32'h100, 1'b0, 4'b0001, '0, 0, 40, ok, lat, bn, rd);
      chk("nomatch_ack", 32'(ok), 32'd0);
      chk("nomatch_busy", 32'(bn), 32'd0);
      do_read("rd0_after_nomatch", 0, 0);

      for (int n = 0; n < 60; n++) begin
         idx = (n % 4 == 0) ? int'($urandom_range(0, 63)) : int'($urandom_range(4, 9));
         if ($urandom_range(0, 1) == 1)
            do_write("rnd_wr", idx, 8'($urandom), 4'($urandom), 1'($urandom));
         else
            do_read("rnd_rd", idx, 1'($urandom));
      end
      for (int i = 4; i <= 9; i++) do_read("final_rd", i, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1);
   end

endmodule
